// File: rtl/ball_pkg.sv
// Shared types, default geometry and helpers for the ball motion datapath.
package ball_pkg;

    typedef enum logic {
        STOPPED = 1'b0,
        ROLLING = 1'b1
    } ball_state_t;

    localparam int DEF_FRAC_BITS = 6;
    localparam int DEF_X_MIN     = 0;
    localparam int DEF_X_MAX     = 608;
    localparam int DEF_Y_MIN     = 0;
    localparam int DEF_Y_MAX     = 448;

    // Negate a w-bit two's-complement value carried in 32 bits. The most-negative value
    // saturates to the most-positive one.
    function automatic logic signed [31:0] sat_neg(input logic signed [31:0] v, input int w);
        logic signed [31:0] v_max;
        v_max = (32'sd1 <<< (w - 1)) - 32'sd1;
        if (v == -v_max - 32'sd1) begin
            return v_max;
        end
        return -v;
    endfunction

endpackage

// File: rtl/ball_axis.sv
// One axis of ball motion: integrate position, reflect off the cushions, step friction.
module ball_axis
    import ball_pkg::*;
#(
    parameter int FRAC_BITS     = DEF_FRAC_BITS,
    parameter int VEL_W         = 11,
    parameter int POS_W         = 11,
    parameter int FRICTION_STEP = 1,
    parameter int LIMIT_MIN     = 0,
    parameter int LIMIT_MAX     = 608,
    parameter int INIT_POS      = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_pos_we,
    input  logic [POS_W-1:0]        i_pos,
    input  logic                    i_vel_we,
    input  logic signed [VEL_W-1:0] i_vel,
    input  logic                    i_frame_update,
    input  logic                    i_friction_tick,
    output logic [POS_W-1:0]        o_pos,
    output logic signed [VEL_W-1:0] o_vel,
    output logic signed [VEL_W-1:0] o_vel_nxt,
    output logic                    o_wall_hit
);

    localparam int PW = POS_W + FRAC_BITS + 2;
    localparam logic signed [PW-1:0]    LO_FX   = PW'(LIMIT_MIN * (2 ** FRAC_BITS));
    localparam logic signed [PW-1:0]    HI_FX   = PW'(LIMIT_MAX * (2 ** FRAC_BITS));
    localparam logic signed [PW-1:0]    INIT_FX = PW'(INIT_POS * (2 ** FRAC_BITS));
    localparam logic signed [VEL_W-1:0] STEP_V  = VEL_W'(FRICTION_STEP);
    localparam logic signed [VEL_W-1:0] ZERO_V  = '0;

    logic signed [PW-1:0]    r_pos;
    logic signed [VEL_W-1:0] r_vel;
    logic                    r_hit;

    logic signed [PW-1:0]    w_pos_in;
    logic signed [PW-1:0]    w_pos_clamped;
    logic signed [PW-1:0]    w_vel_ext;
    logic signed [PW-1:0]    w_pos_nxt;
    logic signed [VEL_W-1:0] w_vel_refl;
    logic signed [VEL_W-1:0] w_vel_nxt;
    logic                    w_hit;

    always_comb begin
        w_pos_in = $signed({2'b00, i_pos, {FRAC_BITS{1'b0}}});
        if (w_pos_in < LO_FX) begin
            w_pos_clamped = LO_FX;
        end else if (w_pos_in > HI_FX) begin
            w_pos_clamped = HI_FX;
        end else begin
            w_pos_clamped = w_pos_in;
        end
    end

    // Integration uses the pre-friction velocity; friction then acts on the reflected one.
    always_comb begin
        w_vel_ext  = PW'(r_vel);
        w_pos_nxt  = r_pos + w_vel_ext;
        w_vel_refl = r_vel;
        w_hit      = 1'b0;
        if (w_pos_nxt < LO_FX) begin
            w_pos_nxt  = LO_FX;
            w_vel_refl = VEL_W'(sat_neg(32'(r_vel), VEL_W));
            w_hit      = 1'b1;
        end else if (w_pos_nxt > HI_FX) begin
            w_pos_nxt  = HI_FX;
            w_vel_refl = VEL_W'(sat_neg(32'(r_vel), VEL_W));
            w_hit      = 1'b1;
        end

        w_vel_nxt = w_vel_refl;
        if (i_friction_tick) begin
            if (w_vel_refl > ZERO_V) begin
                w_vel_nxt = (w_vel_refl <= STEP_V) ? ZERO_V : w_vel_refl - STEP_V;
            end else if (w_vel_refl < ZERO_V) begin
                w_vel_nxt = (w_vel_refl >= -STEP_V) ? ZERO_V : w_vel_refl + STEP_V;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos <= INIT_FX;
            r_vel <= '0;
            r_hit <= 1'b0;
        end else begin
            r_hit <= 1'b0;
            if (i_pos_we) begin
                r_pos <= w_pos_clamped;
                r_vel <= '0;
            end else if (i_vel_we) begin
                r_vel <= i_vel;
            end else if (i_frame_update) begin
                r_pos <= w_pos_nxt;
                r_vel <= w_vel_nxt;
                r_hit <= w_hit;
            end
        end
    end

    assign o_pos      = r_pos[FRAC_BITS +: POS_W];
    assign o_vel      = r_vel;
    assign o_vel_nxt  = w_vel_nxt;
    assign o_wall_hit = r_hit;

endmodule

// File: rtl/ball_kinematics.sv
// Ball motion block: write priority, shared friction counter and rolling/stopped FSM over two axes.
module ball_kinematics
    import ball_pkg::*;
#(
    parameter int FRAC_BITS       = DEF_FRAC_BITS,
    parameter int VEL_W           = 11,
    parameter int POS_W           = 11,
    parameter int FRICTION_FRAMES = 10,
    parameter int FRICTION_STEP   = 1,
    parameter int X_MIN           = DEF_X_MIN,
    parameter int X_MAX           = DEF_X_MAX,
    parameter int Y_MIN           = DEF_Y_MIN,
    parameter int Y_MAX           = DEF_Y_MAX,
    parameter int INIT_X          = 0,
    parameter int INIT_Y          = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    startOfFrame,
    input  logic                    velocityWriteEnable,
    input  logic signed [VEL_W-1:0] inVelocityX,
    input  logic signed [VEL_W-1:0] inVelocityY,
    input  logic                    positionWriteEnable,
    input  logic [POS_W-1:0]        inPosX,
    input  logic [POS_W-1:0]        inPosY,
    output logic [POS_W-1:0]        topLeftPosX,
    output logic [POS_W-1:0]        topLeftPosY,
    output logic signed [VEL_W-1:0] outVelocityX,
    output logic signed [VEL_W-1:0] outVelocityY,
    output logic                    ballStopped,
    output logic                    stoppedPulse,
    output logic                    wallHitX,
    output logic                    wallHitY
);

    localparam int CNT_W = (FRICTION_FRAMES > 1) ? $clog2(FRICTION_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRICTION_FRAMES - 1);

    ball_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stopped_pulse;

    logic                    w_frame_update;
    logic                    w_friction_tick;
    logic signed [VEL_W-1:0] w_vel_nxt_x;
    logic signed [VEL_W-1:0] w_vel_nxt_y;
    logic                    w_load_zero;
    logic                    w_nxt_zero;

    // A frame only advances a rolling ball when no write claims the cycle.
    assign w_frame_update  = startOfFrame && (r_state == ROLLING) &&
                             !positionWriteEnable && !velocityWriteEnable;
    assign w_friction_tick = w_frame_update && (r_cnt == CNT_LAST);
    assign w_load_zero     = (inVelocityX == '0) && (inVelocityY == '0);
    assign w_nxt_zero      = (w_vel_nxt_x == '0) && (w_vel_nxt_y == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= STOPPED;
            r_cnt           <= '0;
            r_stopped_pulse <= 1'b0;
        end else begin
            r_stopped_pulse <= 1'b0;
            if (positionWriteEnable) begin
                r_state <= STOPPED;
                r_cnt   <= '0;
            end else if (velocityWriteEnable) begin
                r_cnt <= '0;
                if (w_load_zero) begin
                    r_state         <= STOPPED;
                    r_stopped_pulse <= (r_state == ROLLING);
                end else begin
                    r_state <= ROLLING;
                end
            end else if (w_frame_update) begin
                r_cnt <= w_friction_tick ? '0 : r_cnt + 1'b1;
                if (w_nxt_zero) begin
                    r_state         <= STOPPED;
                    r_stopped_pulse <= 1'b1;
                end
            end
        end
    end

    ball_axis #(
        .FRAC_BITS     (FRAC_BITS),
        .VEL_W         (VEL_W),
        .POS_W         (POS_W),
        .FRICTION_STEP (FRICTION_STEP),
        .LIMIT_MIN     (X_MIN),
        .LIMIT_MAX     (X_MAX),
        .INIT_POS      (INIT_X)
    ) u_axis_x (
        .clk             (clk),
        .reset           (reset),
        .i_pos_we        (positionWriteEnable),
        .i_pos           (inPosX),
        .i_vel_we        (velocityWriteEnable),
        .i_vel           (inVelocityX),
        .i_frame_update  (w_frame_update),
        .i_friction_tick (w_friction_tick),
        .o_pos           (topLeftPosX),
        .o_vel           (outVelocityX),
        .o_vel_nxt       (w_vel_nxt_x),
        .o_wall_hit      (wallHitX)
    );

    ball_axis #(
        .FRAC_BITS     (FRAC_BITS),
        .VEL_W         (VEL_W),
        .POS_W         (POS_W),
        .FRICTION_STEP (FRICTION_STEP),
        .LIMIT_MIN     (Y_MIN),
        .LIMIT_MAX     (Y_MAX),
        .INIT_POS      (INIT_Y)
    ) u_axis_y (
        .clk             (clk),
        .reset           (reset),
        .i_pos_we        (positionWriteEnable),
        .i_pos           (inPosY),
        .i_vel_we        (velocityWriteEnable),
        .i_vel           (inVelocityY),
        .i_frame_update  (w_frame_update),
        .i_friction_tick (w_friction_tick),
        .o_pos           (topLeftPosY),
        .o_vel           (outVelocityY),
        .o_vel_nxt       (w_vel_nxt_y),
        .o_wall_hit      (wallHitY)
    );

    assign ballStopped  = (r_state == STOPPED);
    assign stoppedPulse = r_stopped_pulse;

endmodule

// File: tb/tb_ball_kinematics.sv
// Directed self-checking bench for ball_kinematics (INIT 100/50, 10-frame friction, step 1).
`timescale 1ns/1ps
module tb_ball_kinematics;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               startOfFrame = 1'b0;
    logic               velocityWriteEnable = 1'b0;
    logic signed [10:0] inVelocityX = '0;
    logic signed [10:0] inVelocityY = '0;
    logic               positionWriteEnable = 1'b0;
    logic [10:0]        inPosX = '0;
    logic [10:0]        inPosY = '0;
    logic [10:0]        topLeftPosX;
    logic [10:0]        topLeftPosY;
    logic signed [10:0] outVelocityX;
    logic signed [10:0] outVelocityY;
    logic               ballStopped;
    logic               stoppedPulse;
    logic               wallHitX;
    logic               wallHitY;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ball_kinematics #(
        .FRAC_BITS       (6),
        .VEL_W           (11),
        .POS_W           (11),
        .FRICTION_FRAMES (10),
        .FRICTION_STEP   (1),
        .X_MIN           (0),
        .X_MAX           (608),
        .Y_MIN           (0),
        .Y_MAX           (448),
        .INIT_X          (100),
        .INIT_Y          (50)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .startOfFrame        (startOfFrame),
        .velocityWriteEnable (velocityWriteEnable),
        .inVelocityX         (inVelocityX),
        .inVelocityY         (inVelocityY),
        .positionWriteEnable (positionWriteEnable),
        .inPosX              (inPosX),
        .inPosY              (inPosY),
        .topLeftPosX         (topLeftPosX),
        .topLeftPosY         (topLeftPosY),
        .outVelocityX        (outVelocityX),
        .outVelocityY        (outVelocityY),
        .ballStopped         (ballStopped),
        .stoppedPulse        (stoppedPulse),
        .wallHitX            (wallHitX),
        .wallHitY            (wallHitY)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic write_vel(input int vx, input int vy);
        velocityWriteEnable = 1'b1;
        inVelocityX = 11'(vx);
        inVelocityY = 11'(vy);
        tick();
        velocityWriteEnable = 1'b0;
    endtask

    task automatic write_pos(input int px, input int py);
        positionWriteEnable = 1'b1;
        inPosX = 11'(px);
        inPosY = 11'(py);
        tick();
        positionWriteEnable = 1'b0;
    endtask

    task automatic test_reset(input string tag);
        reset = 1'b1;
        tick();
        checks++; if (topLeftPosX !== 11'd100) begin errors++;
            $display("FAIL %s_posx: got %0d expected 100", tag, topLeftPosX); end
        checks++; if (topLeftPosY !== 11'd50) begin errors++;
            $display("FAIL %s_posy: got %0d expected 50", tag, topLeftPosY); end
        checks++; if (outVelocityX !== 11'sd0 || outVelocityY !== 11'sd0) begin errors++;
            $display("FAIL %s_vel: got %0d,%0d expected 0,0", tag, outVelocityX, outVelocityY); end
        checks++; if (ballStopped !== 1'b1) begin errors++;
            $display("FAIL %s_stopped: got %b expected 1", tag, ballStopped); end
        checks++; if ({stoppedPulse, wallHitX, wallHitY} !== 3'b000) begin errors++;
            $display("FAIL %s_pulses: got %b expected 000", tag, {stoppedPulse, wallHitX, wallHitY});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_constant_velocity();
        write_vel(64, 0);
        checks++; if (ballStopped !== 1'b0) begin errors++;
            $display("FAIL cv_rolling: got %b expected 0", ballStopped); end
        checks++; if (topLeftPosX !== 11'd100) begin errors++;
            $display("FAIL cv_vel_write_no_move: got %0d expected 100", topLeftPosX); end
        for (int i = 1; i <= 3; i++) begin
            frame();
            checks++; if (topLeftPosX !== 11'(100 + i)) begin errors++;
                $display("FAIL cv_posx_f%0d: got %0d expected %0d", i, topLeftPosX, 100 + i); end
            checks++; if (topLeftPosY !== 11'd50) begin errors++;
                $display("FAIL cv_posy_f%0d: got %0d expected 50", i, topLeftPosY); end
        end
    endtask

    task automatic test_friction();
        int pulses;
        pulses = 0;
        write_vel(3, -2);
        for (int f = 1; f <= 30; f++) begin
            frame();
            if (stoppedPulse === 1'b1) pulses++;
            checks++; if (outVelocityX < 0 || outVelocityY > 0) begin errors++;
                $display("FAIL fr_sign_f%0d: got %0d,%0d expected x>=0,y<=0", f, outVelocityX,
                         outVelocityY); end
            if (f == 10) begin
                checks++; if (outVelocityX !== 11'sd2 || outVelocityY !== -11'sd1) begin errors++;
                    $display("FAIL fr_vel_f10: got %0d,%0d expected 2,-1", outVelocityX,
                             outVelocityY); end
            end else if (f == 20) begin
                checks++; if (outVelocityX !== 11'sd1 || outVelocityY !== 11'sd0) begin errors++;
                    $display("FAIL fr_vel_f20: got %0d,%0d expected 1,0", outVelocityX,
                             outVelocityY); end
            end else if (f == 29) begin
                checks++; if (ballStopped !== 1'b0) begin errors++;
                    $display("FAIL fr_rolling_f29: got %b expected 0", ballStopped); end
            end else if (f == 30) begin
                checks++; if (outVelocityX !== 11'sd0 || outVelocityY !== 11'sd0) begin errors++;
                    $display("FAIL fr_vel_f30: got %0d,%0d expected 0,0", outVelocityX,
                             outVelocityY); end
                checks++; if (ballStopped !== 1'b1 || stoppedPulse !== 1'b1) begin errors++;
                    $display("FAIL fr_stop_f30: got stopped=%b pulse=%b expected 1,1",
                             ballStopped, stoppedPulse); end
            end
        end
        checks++; if (pulses != 1) begin errors++;
            $display("FAIL fr_pulse_count: got %0d expected 1", pulses); end
        // 6400 + 60 units -> 100 px; 3200 - 30 units -> 49 px
        checks++; if (topLeftPosX !== 11'd100 || topLeftPosY !== 11'd49) begin errors++;
            $display("FAIL fr_final_pos: got %0d,%0d expected 100,49", topLeftPosX, topLeftPosY); end
        tick();
        checks++; if (stoppedPulse !== 1'b0) begin errors++;
            $display("FAIL fr_pulse_width: got %b expected 0", stoppedPulse); end
    endtask

    task automatic test_wall();
        write_pos(607, 200);
        write_vel(128, 0);
        frame();
        checks++; if (topLeftPosX !== 11'd608 || outVelocityX !== -11'sd128) begin errors++;
            $display("FAIL wall_x: got pos=%0d vel=%0d expected 608,-128", topLeftPosX,
                     outVelocityX); end
        checks++; if (wallHitX !== 1'b1 || wallHitY !== 1'b0) begin errors++;
            $display("FAIL wall_x_hit: got %b%b expected 10", wallHitX, wallHitY); end
        tick();
        checks++; if (wallHitX !== 1'b0) begin errors++;
            $display("FAIL wall_x_pulse_width: got %b expected 0", wallHitX); end

        write_pos(300, 0);
        write_vel(0, -64);
        frame();
        checks++; if (topLeftPosY !== 11'd0 || outVelocityY !== 11'sd64) begin errors++;
            $display("FAIL wall_y: got pos=%0d vel=%0d expected 0,64", topLeftPosY,
                     outVelocityY); end
        checks++; if (wallHitY !== 1'b1 || wallHitX !== 1'b0) begin errors++;
            $display("FAIL wall_y_hit: got %b%b expected 01", wallHitX, wallHitY); end
        tick();
        checks++; if (wallHitY !== 1'b0) begin errors++;
            $display("FAIL wall_y_pulse_width: got %b expected 0", wallHitY); end
    endtask

    task automatic test_back_to_back();
        // Ball is rolling at (300,0) with velocity (0,64) and a nonzero friction count.
        velocityWriteEnable = 1'b1;
        startOfFrame = 1'b1;
        inVelocityX = 11'sd10;
        inVelocityY = 11'sd20;
        tick();
        velocityWriteEnable = 1'b0;
        startOfFrame = 1'b0;
        checks++; if (topLeftPosX !== 11'd300 || topLeftPosY !== 11'd0) begin errors++;
            $display("FAIL b2b_pos_hold: got %0d,%0d expected 300,0", topLeftPosX, topLeftPosY); end
        checks++; if (outVelocityX !== 11'sd10 || outVelocityY !== 11'sd20) begin errors++;
            $display("FAIL b2b_vel_load: got %0d,%0d expected 10,20", outVelocityX,
                     outVelocityY); end
        for (int i = 0; i < 9; i++) frame();
        checks++; if (outVelocityX !== 11'sd10 || outVelocityY !== 11'sd20) begin errors++;
            $display("FAIL b2b_cnt_f9: got %0d,%0d expected 10,20", outVelocityX, outVelocityY); end
        frame();
        checks++; if (outVelocityX !== 11'sd9 || outVelocityY !== 11'sd19) begin errors++;
            $display("FAIL b2b_cnt_f10: got %0d,%0d expected 9,19", outVelocityX, outVelocityY); end

        positionWriteEnable = 1'b1;
        velocityWriteEnable = 1'b1;
        inPosX = 11'd200;
        inPosY = 11'd100;
        inVelocityX = 11'sd5;
        inVelocityY = 11'sd5;
        tick();
        positionWriteEnable = 1'b0;
        velocityWriteEnable = 1'b0;
        checks++; if (topLeftPosX !== 11'd200 || topLeftPosY !== 11'd100) begin errors++;
            $display("FAIL b2b_pw_pos: got %0d,%0d expected 200,100", topLeftPosX, topLeftPosY); end
        checks++; if (outVelocityX !== 11'sd0 || outVelocityY !== 11'sd0) begin errors++;
            $display("FAIL b2b_pw_vel: got %0d,%0d expected 0,0", outVelocityX, outVelocityY); end
        checks++; if (ballStopped !== 1'b1 || stoppedPulse !== 1'b0) begin errors++;
            $display("FAIL b2b_pw_state: got stopped=%b pulse=%b expected 1,0", ballStopped,
                     stoppedPulse); end
    endtask

    task automatic test_clamp_and_stop();
        write_pos(700, 500);
        checks++; if (topLeftPosX !== 11'd608 || topLeftPosY !== 11'd448) begin errors++;
            $display("FAIL clamp_pos: got %0d,%0d expected 608,448", topLeftPosX, topLeftPosY); end
        checks++; if (ballStopped !== 1'b1 || stoppedPulse !== 1'b0) begin errors++;
            $display("FAIL clamp_state: got stopped=%b pulse=%b expected 1,0", ballStopped,
                     stoppedPulse); end
        frame();
        checks++; if (topLeftPosX !== 11'd608 || ballStopped !== 1'b1) begin errors++;
            $display("FAIL stopped_frame: got pos=%0d stopped=%b expected 608,1", topLeftPosX,
                     ballStopped); end

        write_vel(1, 0);
        write_vel(0, 0);
        checks++; if (ballStopped !== 1'b1 || stoppedPulse !== 1'b1) begin errors++;
            $display("FAIL zero_write_from_rolling: got stopped=%b pulse=%b expected 1,1",
                     ballStopped, stoppedPulse); end
        write_vel(0, 0);
        checks++; if (stoppedPulse !== 1'b0) begin errors++;
            $display("FAIL zero_write_from_stopped: got pulse=%b expected 0", stoppedPulse); end
    endtask

    initial begin
        test_reset("reset");
        test_constant_velocity();
        test_reset("reset_mid_roll");
        test_friction();
        test_wall();
        test_back_to_back();
        test_clamp_and_stop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
